// File: rtl/csr_file_if.sv
// CSR access port between the EXE-stage operand mux (master) and the
// machine-mode CSR file (slave).
interface csr_file_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] csr_write_tmp;
    logic [11:0]       csr_addr_EXE;
    logic [1:0]        csr_op_EXE;
    logic              csr_en_EXE;
    logic [DATA_W-1:0] csr_rdata;
    logic              csr_illegal;

    modport master (
        output csr_write_tmp, csr_addr_EXE, csr_op_EXE, csr_en_EXE,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_write_tmp, csr_addr_EXE, csr_op_EXE, csr_en_EXE,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/RS/RC read-modify-write, 64-bit cycle/instret
// counters, trap entry and mret handling of mstatus.MIE/MPIE.
module csr_file #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] MTVEC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    csr_file_if.slave         bus,
    input  logic              stall,
    input  logic              instr_retire,
    input  logic              trap_en,
    input  logic [DATA_W-1:0] trap_pc,
    input  logic [DATA_W-1:0] trap_cause,
    input  logic              mret_en,
    input  logic              ext_irq,
    input  logic              timer_irq,
    output logic [DATA_W-1:0] mtvec_out,
    output logic [DATA_W-1:0] mepc_out,
    output logic              irq_pending
);
    localparam int               CW       = 2 * DATA_W;
    localparam logic [1:0]       OP_RW    = 2'b01;
    localparam logic [1:0]       OP_RS    = 2'b10;
    localparam logic [DATA_W-1:0] MIE_MASK = DATA_W'(12'h888);
    localparam logic [DATA_W-1:0] ALIGN4  = ~DATA_W'(3);

    logic              r_mstatus_mie;
    logic              r_mstatus_mpie;
    logic [DATA_W-1:0] r_mie;
    logic [DATA_W-1:0] r_mtvec;
    logic [DATA_W-1:0] r_mscratch;
    logic [DATA_W-1:0] r_mepc;
    logic [DATA_W-1:0] r_mcause;
    logic [CW-1:0]     r_mcycle;
    logic [CW-1:0]     r_minstret;

    logic [DATA_W-1:0] w_mstatus;
    logic [DATA_W-1:0] w_mip;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_new;
    logic              w_impl;
    logic              w_ro;
    logic              w_wr_req;
    logic              w_we;
    logic [CW-1:0]     w_mcycle_next;
    logic [CW-1:0]     w_minstret_next;

    always_comb begin
        w_mstatus         = '0;
        w_mstatus[12:11]  = 2'b11;
        w_mstatus[7]      = r_mstatus_mpie;
        w_mstatus[3]      = r_mstatus_mie;
        w_mip             = '0;
        w_mip[7]          = timer_irq;
        w_mip[11]         = ext_irq;
    end

    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (bus.csr_addr_EXE)
            12'h300:          w_rdata = w_mstatus;
            12'h304:          w_rdata = r_mie;
            12'h305:          w_rdata = r_mtvec;
            12'h340:          w_rdata = r_mscratch;
            12'h341:          w_rdata = r_mepc;
            12'h342:          w_rdata = r_mcause;
            12'h344:          w_rdata = w_mip;
            12'hB00, 12'hC00: w_rdata = r_mcycle[DATA_W-1:0];
            12'hB80, 12'hC80: w_rdata = r_mcycle[CW-1:DATA_W];
            12'hB02, 12'hC02: w_rdata = r_minstret[DATA_W-1:0];
            12'hB82, 12'hC82: w_rdata = r_minstret[CW-1:DATA_W];
            default:          w_impl  = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op_EXE)
            OP_RW:   w_new = bus.csr_write_tmp;
            OP_RS:   w_new = w_rdata | bus.csr_write_tmp;
            default: w_new = w_rdata & ~bus.csr_write_tmp;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write.
    assign w_wr_req = bus.csr_en_EXE & ~stall & ~trap_en & (bus.csr_op_EXE != 2'b00)
                    & ((bus.csr_op_EXE == OP_RW) | (|bus.csr_write_tmp));
    assign w_ro     = w_impl & (bus.csr_addr_EXE[11:10] == 2'b11);
    assign w_we     = w_wr_req & w_impl & ~w_ro;

    assign bus.csr_rdata   = w_rdata;
    assign bus.csr_illegal = bus.csr_en_EXE & (~w_impl | (w_wr_req & w_ro));

    // A software write to either counter half replaces that cycle's increment.
    always_comb begin
        w_mcycle_next   = r_mcycle + CW'(1);
        w_minstret_next = r_minstret + CW'(instr_retire & ~stall);
        if (w_we) begin
            case (bus.csr_addr_EXE)
                12'hB00: w_mcycle_next   = {r_mcycle[CW-1:DATA_W], w_new};
                12'hB80: w_mcycle_next   = {w_new, r_mcycle[DATA_W-1:0]};
                12'hB02: w_minstret_next = {r_minstret[CW-1:DATA_W], w_new};
                12'hB82: w_minstret_next = {w_new, r_minstret[DATA_W-1:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST & ALIGN4;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            r_mcycle   <= w_mcycle_next;
            r_minstret <= w_minstret_next;
            if (trap_en) begin
                r_mepc         <= trap_pc & ALIGN4;
                r_mcause       <= trap_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (w_we) begin
                    case (bus.csr_addr_EXE)
                        12'h300: begin
                            r_mstatus_mie  <= w_new[3];
                            r_mstatus_mpie <= w_new[7];
                        end
                        12'h304: r_mie      <= w_new & MIE_MASK;
                        12'h305: r_mtvec    <= w_new & ALIGN4;
                        12'h340: r_mscratch <= w_new;
                        12'h341: r_mepc     <= w_new & ALIGN4;
                        12'h342: r_mcause   <= w_new;
                        default: ;
                    endcase
                end
                // Placed after the write so mret owns MIE/MPIE on a collision.
                if (mret_en) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
            end
        end
    end

    assign mtvec_out   = r_mtvec;
    assign mepc_out    = r_mepc;
    assign irq_pending = r_mstatus_mie & (|(r_mie & w_mip));
endmodule

// File: tb/tb_csr_file.sv
// Scenario bench for csr_file: each step's expected read result is queued when
// the step is driven and checked when the combinational read settles.
module tb_csr_file;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0103;
    localparam logic [1:0]  NONE = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

    typedef struct packed {
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        stall;
        logic        retire;
        logic        trap;
        logic        mret;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } step_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, instr_retire, trap_en, mret_en, ext_irq, timer_irq;
    logic [31:0] trap_pc, trap_cause;
    logic [31:0] mtvec_out, mepc_out;
    logic        irq_pending;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    csr_file_if #(.DATA_W(DATA_W)) bus ();

    csr_file #(.DATA_W(DATA_W), .MTVEC_RST(MTVEC_RST)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stall(stall), .instr_retire(instr_retire),
        .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_en(mret_en), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    function automatic step_t op_step(input logic [1:0] op, input logic [11:0] a,
                                      input logic [31:0] wd, input logic [31:0] exp_rd,
                                      input logic exp_ill);
        step_t s;
        s = '0;
        s.en = 1'b1; s.op = op; s.addr = a; s.wd = wd;
        s.chk = 1'b1; s.exp_rd = exp_rd; s.exp_ill = exp_ill;
        return s;
    endfunction

    function automatic step_t rd_step(input logic [11:0] a, input logic [31:0] exp_rd);
        return op_step(NONE, a, 32'h0, exp_rd, 1'b0);
    endfunction

    function automatic step_t wr_nochk(input logic [1:0] op, input logic [11:0] a,
                                       input logic [31:0] wd);
        step_t s;
        s = op_step(op, a, wd, 32'h0, 1'b0);
        s.chk = 1'b0;
        return s;
    endfunction

    function automatic step_t idle_step();
        step_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply_step(input step_t s);
        exp_t e;
        bus.csr_en_EXE    = s.en;
        bus.csr_op_EXE    = s.op;
        bus.csr_addr_EXE  = s.addr;
        bus.csr_write_tmp = s.wd;
        stall             = s.stall;
        instr_retire      = s.retire;
        trap_en           = s.trap;
        mret_en           = s.mret;
        if (s.chk) begin
            e.rd  = s.exp_rd;
            e.ill = s.exp_ill;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st[$];
        step_t s;
        exp_t  e;
        rst = 1'b0; trap_en = 1'b1; mret_en = 1'b1;
        trap_pc = 32'h44; trap_cause = 32'h5;
        tick(); tick();
        trap_en = 1'b0; mret_en = 1'b0; rst = 1'b1;
        n_cmp++;
        if (mepc_out !== 32'h0) begin
            n_err++; $display("FAIL reset_mepc_out: got %h expected %h", mepc_out, 32'h0);
        end
        n_cmp++;
        if (mtvec_out !== 32'h100) begin
            n_err++; $display("FAIL reset_mtvec_out: got %h expected %h", mtvec_out, 32'h100);
        end
        n_cmp++;
        if (irq_pending !== 1'b0) begin
            n_err++; $display("FAIL reset_irq_pending: got %b expected 0", irq_pending);
        end
        st.push_back(rd_step(12'h305, 32'h0000_0100));
        st.push_back(rd_step(12'h300, 32'h0000_1800));
        st.push_back(rd_step(12'h341, 32'h0));
        st.push_back(rd_step(12'h342, 32'h0));
        st.push_back(rd_step(12'h304, 32'h0));
        st.push_back(op_step(NONE, 12'h7FF, 32'h0, 32'h0, 1'b1));
        s = op_step(NONE, 12'h7FF, 32'h0, 32'h0, 1'b0);
        s.en = 1'b0;
        st.push_back(s);
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("reset[%0d] addr=%h rdata=%h ill=%b", i, st[i].addr, bus.csr_rdata, bus.csr_illegal);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL reset[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
                n_cmp++;
                if (bus.csr_illegal !== e.ill) begin
                    n_err++; $display("FAIL reset[%0d] illegal: got %b expected %b", i, bus.csr_illegal, e.ill);
                end
            end
            tick();
        end
        apply_step(idle_step());
    endtask

    task automatic test_rw_rs_rc();
        step_t st[$];
        exp_t  e;
        st.push_back(op_step(RW, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0));
        st.push_back(op_step(RS, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0));
        st.push_back(op_step(RC, 12'h340, 32'hDE00_0000, 32'hDEAD_BEFF, 1'b0));
        st.push_back(rd_step(12'h340, 32'h00AD_BEFF));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("rw_rs_rc[%0d] op=%0d rdata=%h", i, st[i].op, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL rw_rs_rc[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
                n_cmp++;
                if (bus.csr_illegal !== e.ill) begin
                    n_err++; $display("FAIL rw_rs_rc[%0d] illegal: got %b expected %b", i, bus.csr_illegal, e.ill);
                end
            end
            tick();
        end
        apply_step(idle_step());
    endtask

    task automatic test_masks();
        step_t st[$];
        exp_t  e;
        timer_irq = 1'b1;
        st.push_back(op_step(RW, 12'h305, 32'h0000_0203, 32'h0000_0100, 1'b0));
        st.push_back(rd_step(12'h305, 32'h0000_0200));
        st.push_back(op_step(RW, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0));
        st.push_back(op_step(RW, 12'h304, 32'h0, 32'h0000_0888, 1'b0));
        st.push_back(op_step(RW, 12'h344, 32'h0000_FFFF, 32'h0000_0080, 1'b0));
        st.push_back(rd_step(12'h344, 32'h0000_0080));
        st.push_back(op_step(RW, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0));
        st.push_back(op_step(RW, 12'h300, 32'h0, 32'h0000_1888, 1'b0));
        st.push_back(rd_step(12'h300, 32'h0000_1800));
        st.push_back(op_step(RC, 12'h340, 32'h0, 32'h00AD_BEFF, 1'b0));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("masks[%0d] addr=%h rdata=%h", i, st[i].addr, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL masks[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
                n_cmp++;
                if (bus.csr_illegal !== e.ill) begin
                    n_err++; $display("FAIL masks[%0d] illegal: got %b expected %b", i, bus.csr_illegal, e.ill);
                end
            end
            tick();
        end
        apply_step(idle_step());
        timer_irq = 1'b0;
        n_cmp++;
        if (mtvec_out !== 32'h0000_0200) begin
            n_err++; $display("FAIL masks_mtvec_out: got %h expected %h", mtvec_out, 32'h200);
        end
    endtask

    task automatic test_trap_mret();
        step_t st[$];
        step_t s;
        exp_t  e;
        st.push_back(op_step(RW, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0));
        st.push_back(op_step(RW, 12'h304, 32'h0000_0800, 32'h0, 1'b0));
        st.push_back(rd_step(12'h300, 32'h0000_1808));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("trap_setup[%0d] addr=%h rdata=%h", i, st[i].addr, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL trap_setup[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
            end
            tick();
        end
        apply_step(idle_step());
        n_cmp++;
        if (irq_pending !== 1'b0) begin
            n_err++; $display("FAIL irq_before_ext: got %b expected 0", irq_pending);
        end
        ext_irq = 1'b1;
        #1;
        n_cmp++;
        if (irq_pending !== 1'b1) begin
            n_err++; $display("FAIL irq_ext: got %b expected 1", irq_pending);
        end
        // trap with a concurrent mret: the trap must win
        s = idle_step();
        s.trap = 1'b1; s.mret = 1'b1;
        trap_pc = 32'h0000_0107; trap_cause = 32'h8000_000B;
        apply_step(s);
        tick();
        apply_step(idle_step());
        $display("trap taken mepc_out=%h irq_pending=%b", mepc_out, irq_pending);
        n_cmp++;
        if (mepc_out !== 32'h0000_0104) begin
            n_err++; $display("FAIL trap_mepc_out: got %h expected %h", mepc_out, 32'h104);
        end
        n_cmp++;
        if (irq_pending !== 1'b0) begin
            n_err++; $display("FAIL trap_irq_pending: got %b expected 0", irq_pending);
        end
        st.delete();
        st.push_back(rd_step(12'h341, 32'h0000_0104));
        st.push_back(rd_step(12'h342, 32'h8000_000B));
        st.push_back(rd_step(12'h300, 32'h0000_1880));
        s = op_step(RW, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
        s.mret = 1'b1;
        st.push_back(s);
        st.push_back(rd_step(12'h300, 32'h0000_1888));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("trap_mret[%0d] addr=%h rdata=%h", i, st[i].addr, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL trap_mret[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
            end
            tick();
        end
        apply_step(idle_step());
        n_cmp++;
        if (irq_pending !== 1'b1) begin
            n_err++; $display("FAIL mret_irq_pending: got %b expected 1", irq_pending);
        end
        ext_irq = 1'b0;
        #1;
        n_cmp++;
        if (irq_pending !== 1'b0) begin
            n_err++; $display("FAIL irq_ext_low: got %b expected 0", irq_pending);
        end
    endtask

    task automatic test_counters();
        step_t st[$];
        step_t s;
        exp_t  e;
        st.push_back(wr_nochk(RW, 12'hB00, 32'hFFFF_FFFE));
        st.push_back(wr_nochk(RW, 12'hB80, 32'h0));
        st.push_back(idle_step());
        st.push_back(idle_step());
        st.push_back(idle_step());
        st.push_back(rd_step(12'hB00, 32'h1));
        st.push_back(rd_step(12'hB80, 32'h1));
        st.push_back(wr_nochk(RW, 12'hB00, 32'hFFFF_FFFE));
        st.push_back(wr_nochk(RW, 12'hB80, 32'hFFFF_FFFF));
        st.push_back(idle_step());
        st.push_back(idle_step());
        st.push_back(rd_step(12'hB80, 32'h0));
        st.push_back(rd_step(12'hB00, 32'h1));
        st.push_back(rd_step(12'hC00, 32'h2));
        s = op_step(RW, 12'hB02, 32'h0000_0100, 32'h0, 1'b0);
        s.retire = 1'b1;
        st.push_back(s);
        st.push_back(rd_step(12'hB02, 32'h0000_0100));
        s = idle_step();
        s.retire = 1'b1;
        st.push_back(s);
        st.push_back(rd_step(12'hC02, 32'h0000_0101));
        st.push_back(rd_step(12'hB82, 32'h0));
        st.push_back(rd_step(12'hC82, 32'h0));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("counters[%0d] addr=%h rdata=%h", i, st[i].addr, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL counters[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
            end
            tick();
        end
        apply_step(idle_step());
    endtask

    task automatic test_readonly();
        step_t st[$];
        exp_t  e;
        st.push_back(wr_nochk(RW, 12'hB00, 32'h0000_1000));
        st.push_back(op_step(RW, 12'hC00, 32'h0000_0055, 32'h0000_1000, 1'b1));
        st.push_back(op_step(RS, 12'hC00, 32'h0, 32'h0000_1001, 1'b0));
        st.push_back(op_step(RC, 12'hC80, 32'h0, 32'h0, 1'b0));
        st.push_back(op_step(RW, 12'hC02, 32'h0000_0007, 32'h0000_0101, 1'b1));
        st.push_back(op_step(RS, 12'hC82, 32'h0000_0001, 32'h0, 1'b1));
        st.push_back(rd_step(12'hC00, 32'h0000_1005));
        st.push_back(rd_step(12'hB02, 32'h0000_0101));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("readonly[%0d] addr=%h op=%0d rdata=%h ill=%b", i, st[i].addr, st[i].op, bus.csr_rdata, bus.csr_illegal);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL readonly[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
                n_cmp++;
                if (bus.csr_illegal !== e.ill) begin
                    n_err++; $display("FAIL readonly[%0d] illegal: got %b expected %b", i, bus.csr_illegal, e.ill);
                end
            end
            tick();
        end
        apply_step(idle_step());
    endtask

    task automatic test_stall_trap();
        step_t st[$];
        step_t s;
        exp_t  e;
        trap_pc = 32'h0000_0200; trap_cause = 32'h0000_0002;
        st.push_back(wr_nochk(RW, 12'hB00, 32'h0000_2000));
        s = op_step(RW, 12'h340, 32'h0000_1234, 32'h00AD_BEFF, 1'b0);
        s.stall = 1'b1; s.retire = 1'b1;
        st.push_back(s);
        st.push_back(rd_step(12'hB00, 32'h0000_2001));
        st.push_back(rd_step(12'h340, 32'h00AD_BEFF));
        st.push_back(rd_step(12'hB02, 32'h0000_0101));
        s = op_step(RW, 12'h341, 32'h0000_0999, 32'h0000_0104, 1'b0);
        s.trap = 1'b1;
        st.push_back(s);
        st.push_back(rd_step(12'h341, 32'h0000_0200));
        st.push_back(rd_step(12'h342, 32'h0000_0002));
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            if (st[i].chk) begin
                e = q.pop_front();
                $display("stall_trap[%0d] addr=%h rdata=%h", i, st[i].addr, bus.csr_rdata);
                n_cmp++;
                if (bus.csr_rdata !== e.rd) begin
                    n_err++; $display("FAIL stall_trap[%0d] rdata: got %h expected %h", i, bus.csr_rdata, e.rd);
                end
            end
            tick();
        end
        apply_step(idle_step());
        n_cmp++;
        if (mepc_out !== 32'h0000_0200) begin
            n_err++; $display("FAIL stall_trap_mepc_out: got %h expected %h", mepc_out, 32'h200);
        end
    endtask

    initial begin
        rst = 1'b0;
        ext_irq = 1'b0; timer_irq = 1'b0;
        trap_pc = 32'h0; trap_cause = 32'h0;
        apply_step(idle_step());
        test_reset();
        test_rw_rs_rc();
        test_masks();
        test_trap_mret();
        test_counters();
        test_readonly();
        test_stall_trap();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
